// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_pkg
//  Description : Shared state encodings and default word width for the
//                serializer and the downstream shift-register chain.
//  Revision    : 1.0  initial release
// ============================================================================
package piso_serializer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serializer_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_hold_buf
//  Description : Single-entry word buffer with full flag and load/unload
//                strobes; lets the next word wait while a frame is shifting.
//  Revision    : 1.0  initial release
// ============================================================================
module serializer_hold_buf
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (unload) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            data_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in serial-out stage with valid/ready input and a
//                one-word holding buffer for gap-free back-to-back frames.
//  Revision    : 1.0  initial release
// ============================================================================
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             so_q, so_d;
    logic             so_valid_q, so_valid_d;
    logic             frame_start_q, frame_start_d;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             last_bit;
    logic             shifter_free;
    logic             accept;
    logic             hold_load;
    logic             hold_unload;

    serializer_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk    (clk),
        .rst    (rst),
        .load   (hold_load),
        .unload (hold_unload),
        .din    (din),
        .dout   (hold_data),
        .full   (hold_full)
    );

    always_comb begin
        last_bit     = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
        shifter_free = (state_q == ST_IDLE) || last_bit;
        accept       = din_valid && !hold_full;
        hold_load    = accept && !shifter_free;
        hold_unload  = last_bit && hold_full;

        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shreg_d = din;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    // A held word always wins; it blocks new accepts anyway.
                    if (hold_full) begin
                        shreg_d = hold_data;
                    end else if (accept) begin
                        shreg_d = din;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        so_valid_d    = (state_d == ST_SHIFT);
        frame_start_d = so_valid_d && (cnt_d == '0);
        so_d          = so_valid_d && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            so_q          <= 1'b0;
            so_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            so_q          <= so_d;
            so_valid_q    <= so_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign din_ready   = !hold_full;
    assign busy        = (state_q == ST_SHIFT) || hold_full;
    assign so          = so_q;
    assign so_valid    = so_valid_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Directed vector bench for piso_serializer (MSB- and
//                LSB-first instances, WIDTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

    typedef struct {
        logic       rst;
        logic       dv;
        logic [3:0] din;
        logic [4:0] exp;    // {so, so_valid, frame_start, busy, din_ready}
    } vec_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, din_valid, din_ready, so, so_valid, frame_start, busy;
    logic [3:0] din;
    logic       rst_l, dv_l, rdy_l, so_l, sv_l, fs_l, busy_l;
    logic [3:0] din_l;

    int         n_vec = 0;
    int         n_err = 0;
    vec_t       tbl[$];
    logic [4:0] lsb_exp[5];

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .so(so), .so_valid(so_valid),
        .frame_start(frame_start), .busy(busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst_l), .din(din_l), .din_valid(dv_l),
        .din_ready(rdy_l), .so(so_l), .so_valid(sv_l),
        .frame_start(fs_l), .busy(busy_l)
    );

    task automatic chk(input string name, input int idx,
                       input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] {so,so_valid,frame_start,busy,din_ready}: got %b, want %b",
                     name, idx, act, exp);
        end
    endtask

    initial begin
        // reset held with din_valid high
        tbl.push_back('{1'b1, 1'b1, 4'b1111, 5'b00001});
        tbl.push_back('{1'b1, 1'b1, 4'b1111, 5'b00001});
        // single frame 0011 from IDLE
        tbl.push_back('{1'b0, 1'b1, 4'b0011, 5'b00001});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01111});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        // back-to-back 1010 then 0110 through the hold buffer
        tbl.push_back('{1'b0, 1'b1, 4'b1010, 5'b00001});
        tbl.push_back('{1'b0, 1'b1, 4'b0110, 5'b11111});
        tbl.push_back('{1'b0, 1'b0, 4'b0110, 5'b01010});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11010});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01010});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01111});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        // reset during the second bit with a word held
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 5'b00001});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 5'b11111});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 5'b11010});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        // hold full while upstream offers a different word
        tbl.push_back('{1'b0, 1'b1, 4'b1100, 5'b00001});
        tbl.push_back('{1'b0, 1'b1, 4'b1001, 5'b11111});
        tbl.push_back('{1'b0, 1'b1, 4'b0111, 5'b11010});
        tbl.push_back('{1'b0, 1'b1, 4'b0111, 5'b01010});
        tbl.push_back('{1'b0, 1'b1, 4'b0111, 5'b01010});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11111});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        // direct load on the last bit with hold empty
        tbl.push_back('{1'b0, 1'b1, 4'b0001, 5'b00001});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01111});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01011});
        tbl.push_back('{1'b0, 1'b1, 4'b1110, 5'b11011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11111});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b11011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b01011});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});

        lsb_exp = '{5'b11111, 5'b11011, 5'b01011, 5'b01011, 5'b00001};

        rst = 1'b1; din_valid = 1'b0; din = 4'h0;
        rst_l = 1'b1; dv_l = 1'b0; din_l = 4'h0;
        @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            chk("msb_tbl", i, {so, so_valid, frame_start, busy, din_ready}, tbl[i].exp);
            rst       = tbl[i].rst;
            din_valid = tbl[i].dv;
            din       = tbl[i].din;
        end

        // LSB-first instance: accept 0011, expect 1,1,0,0
        @(negedge clk);
        chk("lsb_rst", 0, {so_l, sv_l, fs_l, busy_l, rdy_l}, 5'b00001);
        rst_l = 1'b0; dv_l = 1'b1; din_l = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dv_l  = 1'b0;
            din_l = 4'h0;
            chk("lsb_frame", k, {so_l, sv_l, fs_l, busy_l, rdy_l}, lsb_exp[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
